// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared scheduler state type and default image geometry
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_HBLANK = 2'd2,
    ST_DRAIN  = 2'd3
  } conv_state_t;

  localparam int DEFAULT_IMAGE_WIDTH   = 320;
  localparam int DEFAULT_IMAGE_HEIGHT  = 240;
  localparam int DEFAULT_HBLANK_CYCLES = 16;
  localparam int DEFAULT_PIPE_LATENCY  = 7;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - fixed-depth delay of a valid strobe and its data word
module valid_delay_line #(
  parameter int DEPTH = 7,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] r_valid_sr;
  logic [WIDTH-1:0] r_data_sr [DEPTH];

  // Clear wipes every stage at once so nothing already in flight emerges later.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_valid_sr <= '0;
      for (int i = 0; i < DEPTH; i++) r_data_sr[i] <= '0;
    end else begin
      r_valid_sr[0] <= i_valid;
      r_data_sr[0]  <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid_sr[i] <= r_valid_sr[i-1];
        r_data_sr[i]  <= r_data_sr[i-1];
      end
    end
  end

  assign o_valid = r_valid_sr[DEPTH-1];
  assign o_data  = r_data_sr[DEPTH-1];

endmodule

// File: rtl/conv_read_scheduler.sv
// rtl/conv_read_scheduler.sv - raster read-address scheduler feeding a pipelined filter
module conv_read_scheduler
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH   = DEFAULT_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT  = DEFAULT_IMAGE_HEIGHT,
  parameter int ADDR_BITS     = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
  parameter int HBLANK_CYCLES = DEFAULT_HBLANK_CYCLES,
  parameter int PIPE_LATENCY  = DEFAULT_PIPE_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 hold,
  input  logic                 abort,
  output logic [ADDR_BITS-1:0] rdaddress,
  output logic                 rd_en,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic                 out_valid,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           frame_count
);

  localparam int COL_W = cnt_bits(IMAGE_WIDTH);
  localparam int ROW_W = cnt_bits(IMAGE_HEIGHT);
  localparam int HB_W  = cnt_bits(HBLANK_CYCLES);
  localparam int DR_W  = cnt_bits(PIPE_LATENCY);

  localparam logic [COL_W-1:0]     COL_LAST  = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0]     ROW_LAST  = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [HB_W-1:0]      HB_LAST   = HB_W'((HBLANK_CYCLES > 0) ? HBLANK_CYCLES - 1 : 0);
  localparam logic [DR_W-1:0]      DR_LAST   = DR_W'(PIPE_LATENCY - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

  conv_state_t          r_state, w_state_nxt;
  logic [COL_W-1:0]     r_col, w_col_nxt;
  logic [ROW_W-1:0]     r_row, w_row_nxt;
  logic [ADDR_BITS-1:0] r_addr, w_addr_nxt;
  logic [HB_W-1:0]      r_hb_cnt, w_hb_nxt;
  logic [DR_W-1:0]      r_dr_cnt, w_dr_nxt;
  logic [7:0]           r_frame_count, w_fc_nxt;
  logic                 w_rd_en;
  logic                 w_done;
  logic                 w_clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_addr        <= '0;
      r_hb_cnt      <= '0;
      r_dr_cnt      <= '0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_col         <= w_col_nxt;
      r_row         <= w_row_nxt;
      r_addr        <= w_addr_nxt;
      r_hb_cnt      <= w_hb_nxt;
      r_dr_cnt      <= w_dr_nxt;
      r_frame_count <= w_fc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_addr_nxt  = r_addr;
    w_hb_nxt    = r_hb_cnt;
    w_dr_nxt    = r_dr_cnt;
    w_fc_nxt    = r_frame_count;
    w_rd_en     = 1'b0;
    w_done      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_STREAM;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
          w_addr_nxt  = '0;
        end
      end
      ST_STREAM: begin
        if (!hold) begin
          w_rd_en    = 1'b1;
          w_addr_nxt = r_addr + 1'b1;
          if (r_col == COL_LAST) begin
            w_col_nxt = '0;
            if (r_row == ROW_LAST) begin
              w_row_nxt   = '0;
              w_addr_nxt  = '0;
              w_dr_nxt    = '0;
              w_state_nxt = ST_DRAIN;
            end else begin
              // The incremented address already equals (row+1)*W for the next line.
              w_row_nxt   = r_row + 1'b1;
              w_hb_nxt    = '0;
              w_state_nxt = (HBLANK_CYCLES > 0) ? ST_HBLANK : ST_STREAM;
            end
          end else begin
            w_col_nxt = r_col + 1'b1;
          end
        end
      end
      ST_HBLANK: begin
        if (!hold) begin
          if (r_hb_cnt == HB_LAST) begin
            w_hb_nxt    = '0;
            w_state_nxt = ST_STREAM;
          end else begin
            w_hb_nxt = r_hb_cnt + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (r_dr_cnt == DR_LAST) begin
          w_done      = 1'b1;
          w_fc_nxt    = r_frame_count + 8'd1;
          w_dr_nxt    = '0;
          w_state_nxt = continuous ? ST_STREAM : ST_IDLE;
        end else begin
          w_dr_nxt = r_dr_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Abort overrides every transition and must not credit a frame.
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_col_nxt   = '0;
      w_row_nxt   = '0;
      w_addr_nxt  = '0;
      w_hb_nxt    = '0;
      w_dr_nxt    = '0;
      w_fc_nxt    = r_frame_count;
    end
    if (abort || reset) w_done = 1'b0;
  end

  assign w_clear     = reset | abort;
  assign rd_en       = w_rd_en;
  assign rdaddress   = r_addr;
  assign frame_start = w_rd_en && (r_addr == '0);
  assign frame_end   = w_rd_en && (r_addr == ADDR_LAST);
  assign busy        = (r_state != ST_IDLE);
  assign done        = w_done;
  assign frame_count = r_frame_count;

  valid_delay_line #(
    .DEPTH (PIPE_LATENCY),
    .WIDTH (ADDR_BITS)
  ) u_delay (
    .clk     (clk),
    .i_clear (w_clear),
    .i_valid (w_rd_en),
    .i_data  (r_addr),
    .o_valid (out_valid),
    .o_data  (out_addr)
  );

endmodule

// File: tb/tb_conv_read_scheduler.sv
// tb/tb_conv_read_scheduler.sv - self-checking bench for conv_read_scheduler on a 4x3 image
module tb_conv_read_scheduler;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int HB    = 2;
  localparam int LAT   = 3;
  localparam int AB    = 4;
  localparam int NPIX  = W * H;
  localparam int NSLOT = W * H + HB * (H - 1) + LAT;
  localparam int MAXC  = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          hold = 1'b0;
  logic          abort = 1'b0;
  logic [AB-1:0] rdaddress;
  logic [AB-1:0] out_addr;
  logic          rd_en, fs, fe, ov, busy, done;
  logic [7:0]    fc;

  always #5 clk = ~clk;

  conv_read_scheduler #(
    .IMAGE_WIDTH   (W),
    .IMAGE_HEIGHT  (H),
    .ADDR_BITS     (AB),
    .HBLANK_CYCLES (HB),
    .PIPE_LATENCY  (LAT)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .start       (start),
    .continuous  (cont),
    .hold        (hold),
    .abort       (abort),
    .rdaddress   (rdaddress),
    .rd_en       (rd_en),
    .frame_start (fs),
    .frame_end   (fe),
    .out_valid   (ov),
    .out_addr    (out_addr),
    .busy        (busy),
    .done        (done),
    .frame_count (fc)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Frame schedule as a flat slot list: 0 = read pixel, 1 = blank, 2 = drain.
  int slot_kind [NSLOT];
  int slot_addr [NSLOT];
  bit m_active = 1'b0;
  int m_idx    = 0;
  int m_fc     = 0;
  bit hist_v [MAXC];
  int hist_a [MAXC];
  int ov_cnt   = 0;
  int rd_hits [16];

  typedef struct {
    logic st; logic hd;
    logic rd; int addr; logic fs; logic fe; logic dn; logic bz;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: actual %0d required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic hd, input logic ab, input logic ct, input logic rs);
    bit e_rd, e_dn;
    int e_addr, kind;
    @(negedge clk);
    start = st; hold = hd; abort = ab; cont = ct; rst = rs;
    #1;
    kind   = m_active ? slot_kind[m_idx] : 1;
    e_addr = m_active ? slot_addr[m_idx] : 0;
    e_rd   = m_active && kind == 0 && !hd;
    e_dn   = m_active && kind == 2 && m_idx == NSLOT - 1 && !ab && !rs;
    chk("busy", busy, m_active);
    chk("rd_en", rd_en, e_rd);
    if (e_rd) chk("rdaddress", rdaddress, e_addr);
    chk("frame_start", fs, e_rd && e_addr == 0);
    chk("frame_end", fe, e_rd && e_addr == NPIX - 1);
    chk("done", done, e_dn);
    chk("frame_count", fc, m_fc);
    chk("out_valid", ov, (cyc >= LAT) ? hist_v[cyc-LAT] : 1'b0);
    if (cyc >= LAT && hist_v[cyc-LAT]) chk("out_addr", out_addr, hist_a[cyc-LAT]);
    if (ov === 1'b1) ov_cnt++;
    if (rd_en === 1'b1) rd_hits[rdaddress]++;
    hist_v[cyc] = e_rd;
    hist_a[cyc] = e_addr;
    if (ab || rs)
      for (int i = cyc - LAT + 1; i <= cyc; i++) if (i >= 0) hist_v[i] = 1'b0;
    if (rs) begin
      m_active = 1'b0; m_idx = 0; m_fc = 0;
    end else if (ab) begin
      m_active = 1'b0; m_idx = 0;
    end else if (!m_active) begin
      if (st) begin m_active = 1'b1; m_idx = 0; end
    end else if (kind == 2) begin
      if (m_idx == NSLOT - 1) begin
        m_fc = (m_fc + 1) % 256;
        if (ct) m_idx = 0; else m_active = 1'b0;
      end else m_idx++;
    end else if (!hd) m_idx++;
    if (cyc < MAXC - 1) cyc++;
  endtask

  task automatic drain_idle(input int budget);
    int n;
    n = 0;
    do begin
      step(0, 0, 0, 0, 0);
      n++;
    end while (busy !== 1'b0 && n < budget);
    chk("idle_reached", busy, 0);
  endtask

  function automatic void add(input logic st, input logic rd, input int addr,
                              input logic f_s, input logic f_e, input logic dn, input logic bz);
    vec_t v;
    v.st = st; v.hd = 1'b0; v.rd = rd; v.addr = addr;
    v.fs = f_s; v.fe = f_e; v.dn = dn; v.bz = bz;
    tbl.push_back(v);
  endfunction

  initial begin
    int k, fc0, dn_seen;
    bit busy_drop, restart_pending;
    logic ct;

    k = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin slot_kind[k] = 0; slot_addr[k] = r * W + c; k++; end
      if (r < H - 1) for (int g = 0; g < HB; g++) begin slot_kind[k] = 1; slot_addr[k] = 0; k++; end
    end
    for (int d = 0; d < LAT; d++) begin slot_kind[k] = 2; slot_addr[k] = 0; k++; end
    for (int i = 0; i < 16; i++) rd_hits[i] = 0;

    // Basic frame: three lines with two-cycle gaps, three-cycle drain, done last.
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1);
    for (int a = 1; a < 4; a++) add(0, 1, a, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0, 1);
    for (int a = 4; a < 8; a++) add(0, 1, a, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0, 1);
    for (int a = 8; a < 11; a++) add(0, 1, a, 0, 0, 0, 1);
    add(0, 1, 11, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0);

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("reset_out_addr", out_addr, 0);
    chk("reset_rdaddress", rdaddress, 0);

    ov_cnt = 0;
    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].hd, 0, 0, 0);
      chk("tbl_rd_en", rd_en, tbl[i].rd);
      if (tbl[i].rd) chk("tbl_addr", rdaddress, tbl[i].addr);
      chk("tbl_frame_start", fs, tbl[i].fs);
      chk("tbl_frame_end", fe, tbl[i].fe);
      chk("tbl_done", done, tbl[i].dn);
      chk("tbl_busy", busy, tbl[i].bz);
    end
    chk("tbl_frame_count", fc, 1);
    chk("tbl_out_valid_count", ov_cnt, NPIX);

    // Hold for five cycles while address 5 is pending.
    ov_cnt = 0;
    for (int i = 0; i < 16; i++) rd_hits[i] = 0;
    step(1, 0, 0, 0, 0);
    repeat (7) step(0, 0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0, 0);
    chk("hold_addr", rdaddress, 5);
    drain_idle(60);
    chk("hold_addr5_once", rd_hits[5], 1);
    chk("hold_out_valid_count", ov_cnt, NPIX);
    chk("hold_frame_count", fc, 2);

    // Three back-to-back frames in continuous mode.
    fc0 = fc; dn_seen = 0; busy_drop = 0; restart_pending = 0;
    step(1, 0, 0, 1, 0);
    for (int n = 0; n < 150 && dn_seen < 3; n++) begin
      ct = (dn_seen < 2);
      step(0, 0, 0, ct, 0);
      if (busy !== 1'b1) busy_drop = 1;
      if (restart_pending) chk("restart_addr0", {27'd0, rd_en, rdaddress}, 32'd16);
      restart_pending = 0;
      if (done === 1'b1) begin dn_seen++; restart_pending = ct; end
    end
    chk("cont_done_pulses", dn_seen, 3);
    chk("cont_busy_never_low", busy_drop, 0);
    drain_idle(5);
    chk("cont_frame_count", fc, (fc0 + 3) % 256);

    // Abort while address 6 is being read.
    fc0 = fc;
    step(1, 0, 0, 0, 0);
    repeat (8) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("abort_at_addr", rdaddress, 6);
    ov_cnt = 0;
    step(0, 0, 0, 0, 0);
    chk("abort_idle", busy, 0);
    repeat (9) step(0, 0, 0, 0, 0);
    chk("abort_no_out_valid", ov_cnt, 0);
    chk("abort_frame_count", fc, fc0);

    // Start while streaming is ignored; abort beats start in IDLE.
    fc0 = fc; ov_cnt = 0;
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    drain_idle(60);
    chk("restart_ignored_ov", ov_cnt, NPIX);
    chk("restart_ignored_fc", fc, (fc0 + 1) % 256);
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("abort_start_idle", busy, 0);

    // Reset during horizontal blanking, then a clean frame.
    step(1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rdaddress", rdaddress, 0);
    chk("rst_frame_start", fs, 0);
    chk("rst_frame_end", fe, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frame_count", fc, 0);
    ov_cnt = 0;
    step(1, 0, 0, 0, 0);
    drain_idle(60);
    chk("post_rst_ov", ov_cnt, NPIX);
    chk("post_rst_fc", fc, 1);

    // Random traffic against the slot-list model.
    ct = 1'b0;
    for (int n = 0; n < 900; n++) begin
      if (n % 64 == 0) ct = logic'($urandom_range(0, 1));
      step(logic'($urandom % 8 == 0), logic'($urandom % 4 == 0),
           logic'($urandom % 97 == 0), ct, logic'($urandom % 211 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
